cpu_pc_ras: RTL and testbench
=============================

// Module: cpu_pc_ras
// PURPOSE
//  Fetch PC generator with a return-address stack (RAS) for call/return prediction.
//  Drives the fetch address (p1_pc) to the instruction bus and holds the address of
//  the instruction now in decode (p2_pc). Redirect priority: reset, execute jump
//  (p3), stall/bubble hold, predicted return, sequential. Parametrised in address
//  width, reset vector, instruction size and stack depth.
// PARAMETERS
//  ADDR_W        32            PC width in bits
//  RESET_VECTOR  32'hFFFF0000  first fetch address after reset
//  INSTR_BYTES   4             sequential increment; power of 2
//  RAS_DEPTH     4             return stack entries; power of 2, >=2
// PORTS
//  clock               in   1       clock; all state on rising edge
//  reset               in   1       synchronous, active-high
//  stall               in   1       pipeline stall: hold PC, no RAS update
//  p2_pipeline_bubble  in   1       decode inserts bubble: refetch p2_pc
//  p2_call             in   1       instruction at p2_pc is a call
//  p2_return           in   1       instruction at p2_pc is a return
//  p3_jump             in   1       execute redirect (taken branch/mispredict)
//  p3_jump_target      in   ADDR_W  redirect address
//  p1_pc               out  ADDR_W  fetch address (combinational)
//  p2_pc               out  ADDR_W  decode-stage PC (registered)
//  p2_predicted        out  1       p2_pc came from a RAS prediction
//  ras_count           out  log2(RAS_DEPTH)+1  valid RAS entries
// BEHAVIOUR
//  - reset: clock/reset as stated (reset synchronous active-high; clock clock).
//  - p1_pc (combinational, first match wins):
//    reset -> RESET_VECTOR; p3_jump -> p3_jump_target with low log2(INSTR_BYTES)
//    bits forced 0; stall|p2_pipeline_bubble -> p2_pc; p2_return & ras_count!=0
//    -> RAS top; else p2_pc+INSTR_BYTES (mod 2^ADDR_W, 0xFFFFFFFC+4 -> 0).
//  - p2_pc <= p1_pc on edge when !stall OR reset (reset overrides stall).
//    After reset edge: p2_pc=RESET_VECTOR, p2_predicted=0, ras_count=0, ptr=0.
//  - p2_predicted <= 1 on an edge where p2_pc loads a RAS-top value, else 0 when
//    p2_pc loads; holds while stalled.
//  - RAS update "effective" only when !reset & !stall & !bubble & !p3_jump
//    (p3_jump squashes the p2 instruction; its call/return is ignored).
//  - Push (p2_call only): entry[ptr] <= p2_pc+INSTR_BYTES; ptr++ (wraps);
//    count++ saturating at RAS_DEPTH; when full, oldest entry overwritten.
//  - Pop (p2_return only, count>0): ptr--, count--; predicts top.
//    Pop when empty: no prediction, sequential fetch, count stays 0, ptr unchanged.
//  - Call+return same cycle: predict from top (if count>0), then overwrite that
//    slot with p2_pc+INSTR_BYTES; ptr and count unchanged. If empty: pure push.
//  - RAS is not repaired on p3_jump; contents survive mispredicts.
//  - Latency: redirect visible on p1_pc same cycle, in p2_pc next edge.
//  - Entries themselves are not cleared by reset (only ptr/count).
// TESTING
//  1 Reset then run: reset 1 cycle -> p2_pc=FFFF0000, then FFFF0004, FFFF0008.
//  2 Stall 3 cycles at p2_pc=100 with p3_jump=0 -> p2_pc stays 100, p1_pc=100;
//    bubble 1 cycle -> p2_pc holds 100 then advances to 104.
//  3 Call at p2_pc=200, later return at p2_pc=300 -> p1_pc=204, p2_pc=204,
//    p2_predicted=1, ras_count 1->0.
//  4 RAS_DEPTH=4: 5 calls at 10,20,30,40,50 -> count=4; 5 returns predict
//    54,44,34,24 then 5th falls through sequential, count stays 0.
//  5 p3_jump target 403 with p2_return and stall asserted -> p1_pc=400,
//    RAS unchanged; reset asserted with stall -> p2_pc=FFFF0000 next edge.
//  6 Call+return same cycle at p2_pc=500 with top=124 -> p1_pc=124, top
//    becomes 504, count unchanged; wrap: p2_pc=FFFFFFFC -> p2_pc=0.

Source files
------------

// File: rtl/cpu_pc_ras.sv
// Fetch PC generator with a return-address stack for call/return prediction.
// p1_pc is the combinational fetch address; p2_pc is the registered decode-stage PC.
module cpu_pc_ras #(
    parameter int                 ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'hFFFF0000,
    parameter int                 INSTR_BYTES  = 4,
    parameter int                 RAS_DEPTH    = 4,
    localparam int                PTR_W        = $clog2(RAS_DEPTH),
    localparam int                CNT_W        = PTR_W + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              p2_pipeline_bubble,
    input  logic              p2_call,
    input  logic              p2_return,
    input  logic              p3_jump,
    input  logic [ADDR_W-1:0] p3_jump_target,
    output logic [ADDR_W-1:0] p1_pc,
    output logic [ADDR_W-1:0] p2_pc,
    output logic              p2_predicted,
    output logic [CNT_W-1:0]  ras_count
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  top_idx;
    logic [ADDR_W-1:0] seq_pc;
    logic              ras_nonempty;
    logic              update_en;
    logic              do_push;
    logic              do_pop;

    // ptr addresses the next free slot; the top of stack sits just below it.
    assign top_idx      = ptr - PTR_W'(1);
    assign seq_pc       = p2_pc + ADDR_W'(INSTR_BYTES);
    assign ras_nonempty = (ras_count != '0);
    assign update_en    = !reset && !stall && !p2_pipeline_bubble && !p3_jump;
    assign do_push      = update_en && p2_call;
    assign do_pop       = update_en && p2_return && ras_nonempty;

    always_comb begin
        if (reset)
            p1_pc = RESET_VECTOR;
        else if (p3_jump)
            p1_pc = p3_jump_target & ALIGN_MASK;
        else if (stall || p2_pipeline_bubble)
            p1_pc = p2_pc;
        else if (p2_return && ras_nonempty)
            p1_pc = ras_mem[top_idx];
        else
            p1_pc = seq_pc;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            p2_pc        <= RESET_VECTOR;
            p2_predicted <= 1'b0;
        end else if (!stall) begin
            p2_pc        <= p1_pc;
            p2_predicted <= do_pop;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr       <= '0;
            ras_count <= '0;
        end else if (do_push && !do_pop) begin
            ptr <= ptr + PTR_W'(1);
            if (ras_count != FULL_COUNT)
                ras_count <= ras_count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            ptr       <= top_idx;
            ras_count <= ras_count - CNT_W'(1);
        end
    end

    // NOTE: stack entries are deliberately not reset; ptr/count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push)
            ras_mem[do_pop ? top_idx : ptr] <= seq_pc;
    end

endmodule

// File: tb/tb_cpu_pc_ras.sv
// Scoreboard bench for cpu_pc_ras: a queue-based return-stack model predicts every
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_cpu_pc_ras;

    localparam logic [31:0] RV = 32'hFFFF0000;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        p2_pipeline_bubble;
    logic        p2_call;
    logic        p2_return;
    logic        p3_jump;
    logic [31:0] p3_jump_target;
    logic [31:0] p1_pc;
    logic [31:0] p2_pc;
    logic        p2_predicted;
    logic [2:0]  ras_count;

    cpu_pc_ras dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .p2_pipeline_bubble (p2_pipeline_bubble),
        .p2_call            (p2_call),
        .p2_return          (p2_return),
        .p3_jump            (p3_jump),
        .p3_jump_target     (p3_jump_target),
        .p1_pc              (p1_pc),
        .p2_pc              (p2_pc),
        .p2_predicted       (p2_predicted),
        .ras_count          (ras_count)
    );

    typedef struct {
        logic [31:0] p1;
        logic [31:0] p2;
        logic        pred;
        int          cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_mis = 0;

    // Reference model: architectural PC plus a bounded stack of return addresses.
    logic [31:0] m_p2;
    logic        m_pred;
    logic [31:0] m_ras[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        if (act !== want) begin
            n_mis++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Monitor: outputs are presented every cycle, compared at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                check("p1_pc", p1_pc, e.p1);
                check("p2_pc", p2_pc, e.p2);
                check("p2_predicted", 32'(p2_predicted), 32'(e.pred));
                check("ras_count", 32'(ras_count), 32'(e.cnt));
            end
        end
    end

    task automatic step(input bit rst, input bit st, input bit bub, input bit call,
                        input bit ret, input bit jmp, input logic [31:0] tgt);
        logic [31:0] p1;
        logic [31:0] old_p2;
        bit          upd;
        bit          pred_sel;
        reset              = rst;
        stall              = st;
        p2_pipeline_bubble = bub;
        p2_call            = call;
        p2_return          = ret;
        p3_jump            = jmp;
        p3_jump_target     = tgt;
        upd      = !rst && !st && !bub && !jmp;
        pred_sel = upd && ret && (m_ras.size() > 0);
        if (rst)           p1 = RV;
        else if (jmp)      p1 = {tgt[31:2], 2'b00};
        else if (st || bub) p1 = m_p2;
        else if (pred_sel) p1 = m_ras[m_ras.size()-1];
        else               p1 = m_p2 + 32'd4;
        sb.push_back('{p1, m_p2, m_pred, m_ras.size()});
        @(posedge clock);
        #1;
        old_p2 = m_p2;
        if (rst) begin
            m_ras.delete();
        end else if (upd) begin
            if (call && ret && m_ras.size() > 0)
                m_ras[m_ras.size()-1] = old_p2 + 32'd4;
            else if (call) begin
                m_ras.push_back(old_p2 + 32'd4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (ret && m_ras.size() > 0)
                void'(m_ras.pop_back());
        end
        if (rst) begin
            m_p2   = RV;
            m_pred = 1'b0;
        end else if (!st) begin
            m_p2   = p1;
            m_pred = pred_sel;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic jump(input logic [31:0] t);
        step(0, 0, 0, 0, 0, 1, t);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; p2_pipeline_bubble = 1'b0;
        p2_call = 1'b0; p2_return = 1'b0; p3_jump = 1'b0; p3_jump_target = '0;
        @(posedge clock);
        #1;
        m_p2 = RV; m_pred = 1'b0; m_ras.delete();

        // Reset then sequential run.
        step(1, 0, 0, 0, 0, 0, 32'h0);
        idle(); idle(); idle();

        // Stall and bubble hold.
        jump(32'h100);
        repeat (3) step(0, 1, 0, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 0, 32'h0);
        idle(); idle();

        // Single call and predicted return.
        jump(32'h200);
        step(0, 0, 0, 1, 0, 0, 32'h0);
        jump(32'h300);
        step(0, 0, 0, 0, 1, 0, 32'h0);
        idle();

        // Overflow the stack, then drain it past empty.
        step(1, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            jump(32'(i) * 32'h10);
            step(0, 0, 0, 1, 0, 0, 32'h0);
        end
        jump(32'h700);
        repeat (5) step(0, 0, 0, 0, 1, 0, 32'h0);
        idle();

        // Jump with return and stall, then reset under stall.
        jump(32'h120);
        step(0, 0, 0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 1, 1, 32'h403);
        idle();
        step(1, 1, 0, 0, 0, 0, 32'h0);
        idle();

        // Call+return same cycle overwrites top; address wrap.
        jump(32'h120);
        step(0, 0, 0, 1, 0, 0, 32'h0);
        jump(32'h500);
        step(0, 0, 0, 1, 1, 0, 32'h0);
        jump(32'h600);
        step(0, 0, 0, 0, 1, 0, 32'h0);
        jump(32'hFFFFFFFC);
        idle(); idle();
        step(0, 0, 0, 1, 1, 0, 32'h0);
        idle();

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            bit          r_rst, r_st, r_bub, r_call, r_ret, r_jmp;
            logic [31:0] r_tgt;
            r_rst  = ($urandom % 64) == 0;
            r_st   = ($urandom % 6) == 0;
            r_bub  = ($urandom % 8) == 0;
            r_call = ($urandom % 4) == 0;
            r_ret  = ($urandom % 4) == 0;
            r_jmp  = ($urandom % 8) == 0;
            r_tgt  = (($urandom % 4) == 0) ? 32'hFFFFFFF0 + ($urandom % 16) : $urandom;
            step(r_rst, r_st, r_bub, r_call, r_ret, r_jmp, r_tgt);
        end
        idle();

        repeat (3) @(negedge clock);
        n_vec++;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
